mem_port_arbiter: RTL

//  Shares one downstream memory port between the instruction-fetch requester and the

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between instruction fetch and load/store.
// Single outstanding transaction; the response goes back to its owner, with optional fetch-response discard.
module mem_port_arbiter #(
    parameter int ADDRW = 32,
    parameter int DATAW = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [ADDRW-1:0]   imem_addr_i,
    input  logic               imem_valid_i,
    input  logic               imem_flush_i,
    output logic [DATAW-1:0]   imem_rdata_o,
    output logic               imem_resp_o,
    input  logic [ADDRW-1:0]   dmem_addr_i,
    input  logic [DATAW-1:0]   dmem_wdata_i,
    input  logic [DATAW/8-1:0] dmem_wmask_i,
    input  logic               dmem_we_i,
    input  logic               dmem_valid_i,
    output logic [DATAW-1:0]   dmem_rdata_o,
    output logic               dmem_resp_o,
    output logic [ADDRW-1:0]   mem_addr_o,
    output logic [DATAW-1:0]   mem_wdata_o,
    output logic [DATAW/8-1:0] mem_wmask_o,
    output logic               mem_we_o,
    output logic               mem_valid_o,
    input  logic               mem_ready_i,
    input  logic [DATAW-1:0]   mem_rdata_i,
    input  logic               mem_resp_i
);
    localparam int MASKW = DATAW / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    // Clears the byte offset so the downstream port only ever sees word addresses.
    function automatic logic [ADDRW-1:0] word_align(input logic [ADDRW-1:0] addr);
        return addr & ~{{(ADDRW-2){1'b0}}, 2'b11};
    endfunction

    state_t state_r;
    owner_t owner_r;
    owner_t last_grant_r;
    logic   discard_r;

    logic   grant_s;
    logic   grant_data_s;
    logic   drop_s;
    logic   resp_cycle_s;
    logic   instr_flush_s;

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        grant_s      = 1'b0;
        grant_data_s = 1'b0;
        if (imem_valid_i && dmem_valid_i) begin
            grant_s      = 1'b1;
            grant_data_s = (last_grant_r == OWN_INSTR);
        end else if (dmem_valid_i) begin
            grant_s      = 1'b1;
            grant_data_s = 1'b1;
        end else if (imem_valid_i) begin
            grant_s      = 1'b1;
            grant_data_s = 1'b0;
        end else begin
            grant_s      = 1'b0;
            grant_data_s = 1'b0;
        end
    end

    // Response routing; a flush in the response cycle itself also drops the fetch data.
    always_comb begin
        drop_s        = discard_r || imem_flush_i;
        resp_cycle_s  = (state_r == ST_WAIT) && mem_resp_i;
        instr_flush_s = imem_flush_i && (owner_r == OWN_INSTR);
        imem_resp_o   = resp_cycle_s && (owner_r == OWN_INSTR) && !drop_s;
        dmem_resp_o   = resp_cycle_s && (owner_r == OWN_DATA);
    end

    assign imem_rdata_o = mem_rdata_i;
    assign dmem_rdata_o = mem_rdata_i;

    // Transaction FSM with the latched downstream request fields.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_INSTR;
            last_grant_r <= OWN_INSTR;
            discard_r    <= 1'b0;
            mem_valid_o  <= 1'b0;
            mem_addr_o   <= {ADDRW{1'b0}};
            mem_wdata_o  <= {DATAW{1'b0}};
            mem_wmask_o  <= {MASKW{1'b0}};
            mem_we_o     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    discard_r <= 1'b0;
                    if (grant_s) begin
                        state_r     <= ST_REQ;
                        mem_valid_o <= 1'b1;
                        if (grant_data_s) begin
                            owner_r      <= OWN_DATA;
                            last_grant_r <= OWN_DATA;
                            mem_addr_o   <= word_align(dmem_addr_i);
                            mem_wdata_o  <= dmem_wdata_i;
                            mem_wmask_o  <= dmem_wmask_i;
                            mem_we_o     <= dmem_we_i;
                        end else begin
                            owner_r      <= OWN_INSTR;
                            last_grant_r <= OWN_INSTR;
                            mem_addr_o   <= word_align(imem_addr_i);
                            mem_wdata_o  <= {DATAW{1'b0}};
                            mem_wmask_o  <= {MASKW{1'b0}};
                            mem_we_o     <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (instr_flush_s) begin
                        discard_r <= 1'b1;
                    end else begin
                        discard_r <= discard_r;
                    end
                    if (mem_ready_i) begin
                        state_r     <= ST_WAIT;
                        mem_valid_o <= 1'b0;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_i) begin
                        state_r   <= ST_IDLE;
                        discard_r <= 1'b0;
                    end else if (instr_flush_s) begin
                        discard_r <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    mem_valid_o <= 1'b0;
                    discard_r   <= 1'b0;
                end
            endcase
        end
    end
endmodule
